write_back_unit: RTL and testbench

//  Parametrised write-back stage for the 5-stage MIPS pipeline. Registers the MEM/WB

---
 rtl/write_back_unit_pkg.sv | 20 ++
 rtl/write_back_unit_if.sv | 38 +++
 rtl/write_back_unit_load_align.sv | 44 ++++
 rtl/write_back_unit.sv | 131 +++++++++++++
 tb/tb_write_back_unit.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/write_back_unit_pkg.sv
// Shared encodings for the MIPS write-back stage: result-source selects,
// load-type codes and a small decode helper.
package write_back_unit_pkg;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_MEM  = 2'b01;
   localparam logic [1:0] WB_SEL_LINK = 2'b10;

   localparam logic [2:0] LD_LW  = 3'b000;
   localparam logic [2:0] LD_LB  = 3'b001;
   localparam logic [2:0] LD_LBU = 3'b010;
   localparam logic [2:0] LD_LH  = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;

   // Halfword loads are the only ones that can fault on a misaligned address.
   function automatic logic isHalfLoad(input logic [2:0] loadType);
      return (loadType == LD_LH) || (loadType == LD_LHU);
   endfunction

endpackage

// File: rtl/write_back_unit_if.sv
// MEM/WB boundary bundle: pipeline control and operands from the memory stage,
// plus the register-file write port, forwarding bus and status outputs.
interface write_back_unit_if #(
   parameter int B  = 32,
   parameter int D  = 5,
   parameter int CW = 32
);
   logic          stall;
   logic          flush;
   logic          in_valid;
   logic [B-1:0]  mem_data;
   logic [B-1:0]  alu_data;
   logic [B-1:0]  link_addr;
   logic [1:0]    wb_sel;
   logic [2:0]    load_type;
   logic [1:0]    byte_off;
   logic          reg_write;
   logic [D-1:0]  dest_reg;

   logic          wb_valid;
   logic          wb_we;
   logic [D-1:0]  wb_addr;
   logic [B-1:0]  wb_data;
   logic          misalign;
   logic [CW-1:0] retire_cnt;

   modport master (
      output stall, flush, in_valid, mem_data, alu_data, link_addr,
             wb_sel, load_type, byte_off, reg_write, dest_reg,
      input  wb_valid, wb_we, wb_addr, wb_data, misalign, retire_cnt
   );

   modport slave (
      input  stall, flush, in_valid, mem_data, alu_data, link_addr,
             wb_sel, load_type, byte_off, reg_write, dest_reg,
      output wb_valid, wb_we, wb_addr, wb_data, misalign, retire_cnt
   );
endinterface

// File: rtl/write_back_unit_load_align.sv
// Big-endian sub-word load alignment: picks the addressed byte or halfword
// from the raw memory word and sign- or zero-extends it to the datapath width.
module write_back_unit_load_align
   import write_back_unit_pkg::*;
#(
   parameter int B = 32
) (
   input  logic [B-1:0] mem_data_i,
   input  logic [2:0]   load_type_i,
   input  logic [1:0]   byte_off_i,
   output logic [B-1:0] aligned_o,
   output logic         misaligned_o
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   // Lane 0 is the most significant byte of the word.
   always_comb begin
      byteSel = mem_data_i[B-1 -: 8];
      case (byte_off_i)
         2'd0: byteSel = mem_data_i[B-1  -: 8];
         2'd1: byteSel = mem_data_i[B-9  -: 8];
         2'd2: byteSel = mem_data_i[B-17 -: 8];
         2'd3: byteSel = mem_data_i[B-25 -: 8];
         default: byteSel = mem_data_i[B-1 -: 8];
      endcase
      halfSel = byte_off_i[1] ? mem_data_i[B-17 -: 16] : mem_data_i[B-1 -: 16];
   end

   always_comb begin
      aligned_o = mem_data_i;
      case (load_type_i)
         LD_LB:   aligned_o = {{(B-8){byteSel[7]}}, byteSel};
         LD_LBU:  aligned_o = {{(B-8){1'b0}}, byteSel};
         LD_LH:   aligned_o = {{(B-16){halfSel[15]}}, halfSel};
         LD_LHU:  aligned_o = {{(B-16){1'b0}}, halfSel};
         default: aligned_o = mem_data_i;
      endcase
   end

   assign misaligned_o = isHalfLoad(load_type_i) & byte_off_i[0];

endmodule

// File: rtl/write_back_unit.sv
// MIPS write-back stage: MEM/WB pipeline register, result-source mux, register
// write-enable qualification and a wrapping retired-instruction counter.
module write_back_unit
   import write_back_unit_pkg::*;
#(
   parameter int B       = 32,
   parameter int D       = 5,
   parameter int CW      = 32,
   parameter bit ZERO_WP = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   write_back_unit_if.slave bus
);

   if ((B % 16) != 0 || B < 16) begin : gBadWidth
      $error("write_back_unit: B must be a non-zero multiple of 16");
   end

   logic          valid_q, valid_d;
   logic          fresh_q, fresh_d;
   logic [B-1:0]  mem_q, mem_d;
   logic [B-1:0]  alu_q, alu_d;
   logic [B-1:0]  link_q, link_d;
   logic [1:0]    sel_q, sel_d;
   logic [2:0]    ldType_q, ldType_d;
   logic [1:0]    off_q, off_d;
   logic          regWrite_q, regWrite_d;
   logic [D-1:0]  dest_q, dest_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [B-1:0]  alignedData;
   logic          misalignedRaw;
   logic          zeroDest;

   // A stall freezes the whole stage; a flush only kills the valid bit, so on
   // stall+flush the data fields keep their old contents. fresh_q marks the
   // first cycle an instruction sits in WB so misalign does not repeat.
   always_comb begin
      valid_d    = valid_q;
      fresh_d    = fresh_q;
      mem_d      = mem_q;
      alu_d      = alu_q;
      link_d     = link_q;
      sel_d      = sel_q;
      ldType_d   = ldType_q;
      off_d      = off_q;
      regWrite_d = regWrite_q;
      dest_d     = dest_q;
      cnt_d      = cnt_q;

      if (!bus.stall) begin
         valid_d    = bus.in_valid;
         fresh_d    = 1'b1;
         mem_d      = bus.mem_data;
         alu_d      = bus.alu_data;
         link_d     = bus.link_addr;
         sel_d      = bus.wb_sel;
         ldType_d   = bus.load_type;
         off_d      = bus.byte_off;
         regWrite_d = bus.reg_write;
         dest_d     = bus.dest_reg;
      end else begin
         fresh_d    = 1'b0;
      end

      if (bus.flush) begin
         valid_d = 1'b0;
      end

      // Counting on the edge that moves an instruction out of WB means a
      // stalled instruction is counted once, when it finally leaves.
      if (valid_q && !bus.stall) begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         fresh_q    <= 1'b0;
         mem_q      <= '0;
         alu_q      <= '0;
         link_q     <= '0;
         sel_q      <= '0;
         ldType_q   <= '0;
         off_q      <= '0;
         regWrite_q <= 1'b0;
         dest_q     <= '0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         fresh_q    <= fresh_d;
         mem_q      <= mem_d;
         alu_q      <= alu_d;
         link_q     <= link_d;
         sel_q      <= sel_d;
         ldType_q   <= ldType_d;
         off_q      <= off_d;
         regWrite_q <= regWrite_d;
         dest_q     <= dest_d;
         cnt_q      <= cnt_d;
      end
   end

   write_back_unit_load_align #(.B(B)) uAlign (
      .mem_data_i   (mem_q),
      .load_type_i  (ldType_q),
      .byte_off_i   (off_q),
      .aligned_o    (alignedData),
      .misaligned_o (misalignedRaw)
   );

   // Reserved select code 11 falls through to the ALU result.
   always_comb begin
      bus.wb_data = alu_q;
      case (sel_q)
         WB_SEL_MEM:  bus.wb_data = alignedData;
         WB_SEL_LINK: bus.wb_data = link_q;
         default:     bus.wb_data = alu_q;
      endcase
   end

   assign zeroDest       = ZERO_WP && (dest_q == '0);
   assign bus.wb_valid   = valid_q;
   assign bus.wb_addr    = dest_q;
   assign bus.wb_we      = valid_q & regWrite_q & ~misalignedRaw & ~zeroDest;
   assign bus.misalign   = valid_q & fresh_q & misalignedRaw;
   assign bus.retire_cnt = cnt_q;

endmodule

// File: tb/tb_write_back_unit.sv
// Scoreboard bench for write_back_unit: directed rows push expected WB outputs,
// a monitor pops and compares one entry after every clock edge.
module tb_write_back_unit;
   import write_back_unit_pkg::*;

   typedef struct packed {
      int unsigned row;
      logic        valid;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        mis;
      logic [3:0]  cnt;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   rowNum = 0;
   exp_t expQ[$];

   write_back_unit_if #(.B(32), .D(5), .CW(4)) bus ();

   write_back_unit #(.B(32), .D(5), .CW(4), .ZERO_WP(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic exp_t mkExp(input logic v, we, input logic [4:0] a,
                                  input logic [31:0] d, input logic m, input logic [3:0] c);
      exp_t e;
      e.row = 0; e.valid = v; e.we = we; e.addr = a; e.data = d; e.mis = m; e.cnt = c;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic applyStimulus(input logic st, fl, iv, rw, input logic [1:0] sel,
                                input logic [2:0] lt, input logic [1:0] off,
                                input logic [4:0] dst, input logic [31:0] mem, alu, link,
                                input exp_t e);
      @(negedge clk);
      bus.stall     = st;
      bus.flush     = fl;
      bus.in_valid  = iv;
      bus.reg_write = rw;
      bus.wb_sel    = sel;
      bus.load_type = lt;
      bus.byte_off  = off;
      bus.dest_reg  = dst;
      bus.mem_data  = mem;
      bus.alu_data  = alu;
      bus.link_addr = link;
      rowNum++;
      e.row = rowNum;
      expQ.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      if (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         checkOutput($sformatf("row%0d.valid", e.row), 32'(bus.wb_valid), 32'(e.valid));
         checkOutput($sformatf("row%0d.we", e.row), 32'(bus.wb_we), 32'(e.we));
         checkOutput($sformatf("row%0d.addr", e.row), 32'(bus.wb_addr), 32'(e.addr));
         checkOutput($sformatf("row%0d.data", e.row), bus.wb_data, e.data);
         checkOutput($sformatf("row%0d.misalign", e.row), 32'(bus.misalign), 32'(e.mis));
         checkOutput($sformatf("row%0d.cnt", e.row), 32'(bus.retire_cnt), 32'(e.cnt));
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".valid"}, 32'(bus.wb_valid), 32'd0);
      checkOutput({tag, ".we"}, 32'(bus.wb_we), 32'd0);
      checkOutput({tag, ".addr"}, 32'(bus.wb_addr), 32'd0);
      checkOutput({tag, ".data"}, bus.wb_data, 32'd0);
      checkOutput({tag, ".misalign"}, 32'(bus.misalign), 32'd0);
      checkOutput({tag, ".cnt"}, 32'(bus.retire_cnt), 32'd0);
   endtask

   localparam logic [31:0] MEMW = 32'h80FF_7F01;

   initial begin
      bus.stall = 0; bus.flush = 0; bus.in_valid = 0; bus.reg_write = 0;
      bus.wb_sel = 0; bus.load_type = 0; bus.byte_off = 0; bus.dest_reg = 0;
      bus.mem_data = 0; bus.alu_data = 0; bus.link_addr = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;

      // st fl iv rw sel lt off dst mem alu link  -> expected after the edge
      applyStimulus(0,0,1,1,WB_SEL_ALU,LD_LW,0,5,MEMW,32'h0000_1234,0, mkExp(1,1,5,32'h0000_1234,0,4'd0));
      applyStimulus(0,0,1,1,WB_SEL_MEM,LD_LB,0,6,MEMW,0,0,  mkExp(1,1,6,32'hFFFF_FF80,0,4'd1));
      applyStimulus(0,0,1,1,WB_SEL_MEM,LD_LBU,1,7,MEMW,0,0, mkExp(1,1,7,32'h0000_00FF,0,4'd2));
      applyStimulus(0,0,1,1,WB_SEL_MEM,LD_LH,2,8,MEMW,0,0,  mkExp(1,1,8,32'h0000_7F01,0,4'd3));
      applyStimulus(0,0,1,1,WB_SEL_MEM,LD_LHU,0,9,MEMW,0,0, mkExp(1,1,9,32'h0000_80FF,0,4'd4));
      applyStimulus(0,0,1,1,WB_SEL_MEM,LD_LH,1,10,MEMW,0,0, mkExp(1,0,10,32'hFFFF_80FF,1,4'd5));
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1,0,1,1,WB_SEL_ALU,LD_LW,0,11,MEMW,32'h0000_5555,0, mkExp(1,0,10,32'hFFFF_80FF,0,4'd5));
      end
      applyStimulus(0,0,1,1,WB_SEL_ALU,LD_LW,0,11,MEMW,32'h0000_5555,0, mkExp(1,1,11,32'h0000_5555,0,4'd6));
      applyStimulus(0,0,1,1,WB_SEL_LINK,LD_LW,0,31,MEMW,0,32'h0040_0008, mkExp(1,1,31,32'h0040_0008,0,4'd7));
      applyStimulus(0,0,1,1,2'b11,3'b111,0,12,MEMW,32'h0000_ABCD,0, mkExp(1,1,12,32'h0000_ABCD,0,4'd8));
      applyStimulus(0,0,1,1,WB_SEL_MEM,3'b101,3,13,MEMW,0,0, mkExp(1,1,13,MEMW,0,4'd9));
      applyStimulus(0,0,1,1,WB_SEL_ALU,LD_LW,0,0,MEMW,32'h0000_0042,0, mkExp(1,0,0,32'h0000_0042,0,4'd10));
      applyStimulus(1,1,1,1,WB_SEL_ALU,LD_LW,0,3,MEMW,32'h0000_9999,0, mkExp(0,0,0,32'h0000_0042,0,4'd10));
      applyStimulus(0,0,0,1,WB_SEL_ALU,LD_LW,0,4,MEMW,32'h0000_7777,0, mkExp(0,0,4,32'h0000_7777,0,4'd10));
      applyStimulus(0,1,1,1,WB_SEL_ALU,LD_LW,0,2,MEMW,32'h0000_1111,0, mkExp(0,0,2,32'h0000_1111,0,4'd10));
      applyStimulus(0,0,1,0,WB_SEL_ALU,LD_LW,0,3,MEMW,32'h0000_2222,0, mkExp(1,0,3,32'h0000_2222,0,4'd10));
      for (int k = 0; k < 7; k++) begin
         logic [3:0] c;
         c = 4'(11 + k);
         applyStimulus(0,0,1,1,WB_SEL_ALU,LD_LW,0,5'(k+1),MEMW,32'h100 + 32'(k),0,
                       mkExp(1,1,5'(k+1),32'h100 + 32'(k),0,c));
      end

      // Asynchronous reset between edges with a valid instruction in flight.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      checkAllZero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0,0,1,1,WB_SEL_ALU,LD_LW,0,5,MEMW,32'h0000_0ABC,0, mkExp(1,1,5,32'h0000_0ABC,0,4'd0));
      applyStimulus(0,0,0,1,WB_SEL_ALU,LD_LW,0,6,MEMW,32'h0000_0DEF,0, mkExp(0,0,6,32'h0000_0DEF,0,4'd1));

      for (int w = 0; w < 5 && expQ.size() > 0; w++) @(negedge clk);
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: actual=%0d pending required=0 pending", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
